// File: rtl/ysyx_24100012_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_24100012_mem_responder
// Purpose  : Memory-side responder for fetch / load-store requests. Accepts
//            one request at a time, waits LATENCY cycles, then returns one
//            response. Storage is a word-addressed array at ORIGIN_ADDR.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            req_valid/ready   - request handshake
//            req_we/addr/wdata/wmask - request payload (addr[1:0] ignored)
//            rsp_valid/ready   - response handshake
//            rsp_rdata, rsp_err - read data (0 on writes/errors), range error
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_24100012_mem_responder #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] ORIGIN_ADDR = 32'h80000000,
    parameter int                    DEPTH_WORDS = 1024,
    parameter int                    LATENCY     = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wmask,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err
);

    localparam int                    c_MASK_W   = DATA_WIDTH / 8;
    localparam int                    c_IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_WIDTH-1:0] c_SPAN     = ADDR_WIDTH'(4 * DEPTH_WORDS);
    localparam logic [3:0]            c_CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state_q,     state_d;
    logic [3:0]              cnt_q,       cnt_d;
    logic                    we_q,        we_d;
    logic [ADDR_WIDTH-1:0]   addr_q,      addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q,     wdata_d;
    logic [c_MASK_W-1:0]     wmask_q,     wmask_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q,   rsp_err_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH_WORDS];
    logic                    mem_wr_en;
    logic [ADDR_WIDTH-1:0]   offset;
    logic                    in_range;
    logic [c_IDX_W-1:0]      index;

    // Full-width subtraction: addresses below the origin wrap to huge
    // offsets and therefore fail the range compare.
    assign offset   = addr_q - ORIGIN_ADDR;
    assign in_range = (offset < c_SPAN);
    assign index    = offset[c_IDX_W+1:2];

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wmask_d = req_wmask;
                    cnt_d   = c_CNT_LOAD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = RESP;
                    if (in_range) begin
                        rsp_rdata_d = we_q ? '0 : mem[index];
                        rsp_err_d   = 1'b0;
                        mem_wr_en   = we_q;
                    end else begin
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b1;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Array is not reset; a write whose commit edge coincides with reset
    // is suppressed so a dropped transaction never lands.
    always_ff @(posedge clk) begin
        if (!rst && mem_wr_en) begin
            for (int i = 0; i < c_MASK_W; i++) begin
                if (wmask_q[i]) begin
                    mem[index][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    // Requester must hold the payload while a request waits unaccepted;
    // withdrawing req_valid is allowed.
    a_req_stable: assert property (@(posedge clk) disable iff (rst)
        (req_valid && !req_ready) |=>
            (!req_valid || ($stable(req_we) && $stable(req_addr) &&
                            $stable(req_wdata) && $stable(req_wmask))));

endmodule
`default_nettype wire
